sram_port_arbiter: RTL

- Shares one single-port SRAM-like memory interface between the instruction-fetch requester and the data-access requester of the CPU core.
- Grants are made one transaction at a time. Data requests have priority, with a starvation guard for fetch.
- Each transaction is sequenced through a fixed-latency memory access, and completion is signalled per requester with a one-cycle data_ok pulse.
- Sits between the core's fetch/memory stages and the address-translation/SRAM path.

---
 rtl/sram_port_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//
// Shares one single-port SRAM-like memory interface between the instruction
// fetch requester and the data access requester. One transaction is in flight
// at a time. Data wins ties unless fetch has been passed over STARVE_MAX times
// in a row while waiting, in which case fetch is forced through.
//
// Each transaction walks IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> RESP.
// The one-cycle mem_en strobe is raised in ISSUE. Read data is captured on the
// last WAIT cycle. The owner's data_ok pulses in RESP.
//
// Parameters:
//   MEM_LATENCY  cycles from the mem_en cycle to valid mem_rdata (1..7)
//   STARVE_MAX   consecutive data grants tolerated while fetch waits (1..15)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   inst_req/inst_addr            fetch request and address
//   inst_rdata/inst_data_ok       fetch read data and completion pulse
//   data_req/data_wen/data_addr/data_wdata
//                                 data request, byte enables, address and store data
//   data_rdata/data_data_ok       load data and completion pulse
//   mem_en/mem_wen/mem_addr/mem_wdata
//                                 memory access strobe and write controls
//   mem_rdata                     memory read data
//   perf_conflict_cnt             count of grants made while both requesters waited
//
// Build option:
//   SRAM_ARB_PERF_CNT_EN  when defined, perf_conflict_cnt is a live counter.
//                         Otherwise it is tied to zero.

module sram_port_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter int STARVE_MAX  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_data_ok,
    output logic        mem_en,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] perf_conflict_cnt
);

    localparam logic [2:0] LAT_LOAD   = 3'(MEM_LATENCY);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateT;

    stateT       r_state;
    logic        r_ownerData;
    logic [3:0]  r_starveCnt;
    logic [2:0]  r_latCnt;
    logic        r_memEn;
    logic [3:0]  r_memWen;
    logic [31:0] r_memAddr;
    logic [31:0] r_memWdata;
    logic [31:0] r_instRdata;
    logic [31:0] r_dataRdata;
    logic        r_instOk;
    logic        r_dataOk;

    logic        w_grantData;
    logic        w_grantInst;

    // Data normally wins. Once fetch has been passed over STARVE_MAX times
    // while waiting, fetch takes the next slot.
    assign w_grantData = data_req && !(inst_req && (r_starveCnt == STARVE_LIM));
    assign w_grantInst = !w_grantData && inst_req;

    // Main sequencer. All outputs are registered here, so mem_en appears the
    // cycle after the grant and data_ok the cycle after the capture.
    // mem_addr and mem_wdata double as the latched transaction fields and
    // keep their values between accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ownerData <= 1'b0;
            r_starveCnt <= 4'd0;
            r_latCnt    <= 3'd0;
            r_memEn     <= 1'b0;
            r_memWen    <= 4'd0;
            r_memAddr   <= 32'd0;
            r_memWdata  <= 32'd0;
            r_instRdata <= 32'd0;
            r_dataRdata <= 32'd0;
            r_instOk    <= 1'b0;
            r_dataOk    <= 1'b0;
        end else begin
            r_instOk <= 1'b0;
            r_dataOk <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grantData || w_grantInst) begin
                        r_ownerData <= w_grantData;
                        r_memEn     <= 1'b1;
                        r_memWen    <= w_grantData ? data_wen : 4'd0;
                        r_memAddr   <= w_grantData ? data_addr : inst_addr;
                        r_memWdata  <= data_wdata;
                        r_state     <= ISSUE;
                        if (w_grantData && inst_req) begin
                            if (r_starveCnt != STARVE_LIM)
                                r_starveCnt <= r_starveCnt + 4'd1;
                        end else begin
                            r_starveCnt <= 4'd0;
                        end
                    end
                end
                ISSUE: begin
                    r_memEn  <= 1'b0;
                    r_memWen <= 4'd0;
                    r_latCnt <= LAT_LOAD;
                    r_state  <= WAIT;
                end
                WAIT: begin
                    r_latCnt <= r_latCnt - 3'd1;
                    if (r_latCnt == 3'd1) begin
                        if (r_ownerData) begin
                            r_dataRdata <= mem_rdata;
                            r_dataOk    <= 1'b1;
                        end else begin
                            r_instRdata <= mem_rdata;
                            r_instOk    <= 1'b1;
                        end
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_en       = r_memEn;
    assign mem_wen      = r_memWen;
    assign mem_addr     = r_memAddr;
    assign mem_wdata    = r_memWdata;
    assign inst_rdata   = r_instRdata;
    assign inst_data_ok = r_instOk;
    assign data_rdata   = r_dataRdata;
    assign data_data_ok = r_dataOk;

`ifdef SRAM_ARB_PERF_CNT_EN
    logic [31:0] r_perfCnt;
    logic        w_conflict;

    // Any request seen in IDLE produces a grant, so both requests high in
    // IDLE marks one contested grant.
    assign w_conflict = (r_state == IDLE) && inst_req && data_req;

    // The counter wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst)
            r_perfCnt <= 32'd0;
        else if (w_conflict)
            r_perfCnt <= r_perfCnt + 32'd1;
    end

    assign perf_conflict_cnt = r_perfCnt;
`else
    assign perf_conflict_cnt = 32'd0;
`endif

endmodule
